demon_tick_arbiter: RTL and testbench

DEMON_TICK_ARBITER -- requirements
Module: demon_tick_arbiter

---
 rtl/demon_tick_arbiter.sv | 139 +++++++++++++
 tb/tb_demon_tick_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/demon_tick_arbiter.sv
// Tick-paced round-robin arbiter: 4 requesters share one unit; new grants are issued only on prescaler ticks.
// Optional grant timeout compiled in with `define DEMON_TICK_ARBITER_TIMEOUT_EN.
module demon_tick_arbiter #(
  parameter int unsigned MAX_COUNT  = 10_000_000,
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       grant_valid,
  output logic [1:0] grant_id,
  output logic       tick,
  output logic       timeout
);

  localparam int unsigned CW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_COUNT - 1);

  typedef enum logic {IDLE, GRANTED} state_t;

  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q;
  logic [3:0]    grant_q;
  logic          grant_valid_q;
  logic [1:0]    grant_id_q;
  logic [1:0]    rr_ptr_q;

  logic [1:0]    cand_idx [4];
  logic          sel_found;
  logic [1:0]    sel_idx;

  // Free-running prescaler, independent of arbitration state.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);

  for (genvar gi = 0; gi < 4; gi++) begin : g_cand
    assign cand_idx[gi] = rr_ptr_q + 2'(gi);
  end

  // Walk candidates from farthest to nearest so the nearest set bit wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 3; i >= 0; i--) begin
      if (req[cand_idx[i]]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx[i];
      end
    end
  end

`ifdef DEMON_TICK_ARBITER_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);
  logic [7:0] hold_q;
  logic       timeout_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
`ifdef DEMON_TICK_ARBITER_TIMEOUT_EN
      hold_q        <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
`ifdef DEMON_TICK_ARBITER_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (tick && sel_found) begin
            state_q       <= GRANTED;
            grant_q       <= 4'b0001 << sel_idx;
            grant_valid_q <= 1'b1;
            grant_id_q    <= sel_idx;
            rr_ptr_q      <= sel_idx + 2'd1;
`ifdef DEMON_TICK_ARBITER_TIMEOUT_EN
            hold_q        <= '0;
`endif
          end
        end
        GRANTED: begin
          // Release takes priority over a coincident timeout tick.
          if (!req[grant_id_q]) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
`ifdef DEMON_TICK_ARBITER_TIMEOUT_EN
          end else if (tick) begin
            if (hold_q == HOLD_LAST) begin
              state_q       <= IDLE;
              grant_q       <= '0;
              grant_valid_q <= 1'b0;
              grant_id_q    <= '0;
              timeout_q     <= 1'b1;
            end else begin
              hold_q <= hold_q + 8'd1;
            end
`endif
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

`ifdef DEMON_TICK_ARBITER_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_demon_tick_arbiter.sv
// Directed bench for demon_tick_arbiter (MAX_COUNT=4, HOLD_TICKS=2) with a per-cycle expectation queue.
module tb_demon_tick_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       tick;
  logic       timeout;

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;

  typedef struct {
    logic [3:0] g;
    logic       to;
    logic       tk;
    string      tag;
  } exp_t;

  exp_t sb[$];

  demon_tick_arbiter #(.MAX_COUNT(4), .HOLD_TICKS(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .tick        (tick),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] oh2id(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_empty at cycle %0d: got no entry, required one", cyc_n);
      return;
    end
    e = sb.pop_front();
    tests++;
    assert (grant === e.g) else begin
      fails++;
      $error("FAIL %s grant cyc%0d: got %b expected %b", e.tag, cyc_n, grant, e.g);
    end
    tests++;
    assert (grant_valid === (|e.g)) else begin
      fails++;
      $error("FAIL %s grant_valid cyc%0d: got %b expected %b", e.tag, cyc_n, grant_valid, |e.g);
    end
    tests++;
    assert (grant_id === oh2id(e.g)) else begin
      fails++;
      $error("FAIL %s grant_id cyc%0d: got %0d expected %0d", e.tag, cyc_n, grant_id, oh2id(e.g));
    end
    tests++;
    assert (tick === e.tk) else begin
      fails++;
      $error("FAIL %s tick cyc%0d: got %b expected %b", e.tag, cyc_n, tick, e.tk);
    end
    tests++;
    assert (timeout === e.to) else begin
      fails++;
      $error("FAIL %s timeout cyc%0d: got %b expected %b", e.tag, cyc_n, timeout, e.to);
    end
    $display("[TB] cyc %0d %s req=%b grant=%b id=%0d tick=%b timeout=%b", cyc_n, e.tag, req, grant,
             grant_id, tick, timeout);
  endtask

  // Drive req for the current cycle; expectation is for the following cycle.
  task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic eto, input string tag);
    exp_t e;
    req   = r;
    e.g   = eg;
    e.to  = eto;
    e.tk  = ((cyc_n + 1) % 4) == 3;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc_n++;
    check_front();
  endtask

  task automatic do_reset(input string tag);
    exp_t e;
    reset = 1'b1;
    e.g   = 4'b0000;
    e.to  = 1'b0;
    e.tk  = 1'b0;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_front();
    reset = 1'b0;
    cyc_n = 0;
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] eg;
    logic       eto;
    int         n;
    int         ph;
    req = 4'b0000;
    do_reset("reset");

    // Idle: ticks at cycles 3, 7, 11; no grant.
    for (int c = 0; c < 12; c++) step(4'b0000, 4'b0000, 1'b0, "idle");

    // Requesters 0 and 2: 0 granted at tick 15, releases, 2 granted at tick 19.
    step(4'b0101, 4'b0000, 1'b0, "rr_wait");
    step(4'b0101, 4'b0000, 1'b0, "rr_wait");
    step(4'b0101, 4'b0000, 1'b0, "rr_wait");
    step(4'b0101, 4'b0001, 1'b0, "rr_g0");
    step(4'b0101, 4'b0001, 1'b0, "rr_g0");
    step(4'b0101, 4'b0001, 1'b0, "rr_g0");
    step(4'b0100, 4'b0000, 1'b0, "rr_rel0");
    step(4'b0100, 4'b0100, 1'b0, "rr_g2");
    step(4'b0100, 4'b0100, 1'b0, "rr_g2");
    step(4'b0000, 4'b0000, 1'b0, "rr_rel2");
    // Requester 3 drops before any tick: no grant at tick 23.
    step(4'b1000, 4'b0000, 1'b0, "drop_ungranted");
    step(4'b0000, 4'b0000, 1'b0, "drop_ungranted");

    // rr_ptr=3: tick 27 grants 3, then reset mid-grant.
    step(4'b1010, 4'b0000, 1'b0, "pre_rst");
    step(4'b1010, 4'b0000, 1'b0, "pre_rst");
    step(4'b1010, 4'b0000, 1'b0, "pre_rst");
    step(4'b1010, 4'b1000, 1'b0, "pre_rst_g3");
    step(4'b1010, 4'b1000, 1'b0, "pre_rst_g3");
    do_reset("reset_mid_grant");

    // All four requesting: rotation 0,1,2,3,0 starting from index 0 after reset.
    step(4'b1111, 4'b0000, 1'b0, "all_wait");
    step(4'b1111, 4'b0000, 1'b0, "all_wait");
    step(4'b1111, 4'b0000, 1'b0, "all_wait");
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << (k % 4);
      step(4'b1111, g, 1'b0, "all_grant");
      step(4'b1111, g, 1'b0, "all_grant");
      step(4'b1111 & ~g, 4'b0000, 1'b0, "all_release");
      step(4'b1111, 4'b0000, 1'b0, "all_idle");
    end
    // Tick at cycle 23 with no request: stays idle.
    step(4'b0000, 4'b0000, 1'b0, "tick_no_req");

    // Requester 1 held from cycle 24; granted at cycle 28.
    for (int c = 24; c < 64; c++) begin
      n = c + 1;
`ifdef DEMON_TICK_ARBITER_TIMEOUT_EN
      ph  = (n - 28) % 12;
      eg  = (n >= 28 && ph < 8) ? 4'b0010 : 4'b0000;
      eto = (n >= 28 && ph == 8);
`else
      ph  = 0;
      eg  = (n >= 28) ? 4'b0010 : 4'b0000;
      eto = 1'b0;
`endif
      step(4'b0010, eg, eto, "hold");
    end
    step(4'b0000, 4'b0000, 1'b0, "hold_release");

    // Requester 0 granted at tick 67, releases on tick 71 while 2 requests: no grant until tick 75.
    step(4'b0001, 4'b0000, 1'b0, "rel_tick_wait");
    step(4'b0001, 4'b0000, 1'b0, "rel_tick_wait");
    step(4'b0001, 4'b0001, 1'b0, "rel_tick_g0");
    step(4'b0001, 4'b0001, 1'b0, "rel_tick_g0");
    step(4'b0001, 4'b0001, 1'b0, "rel_tick_g0");
    step(4'b0001, 4'b0001, 1'b0, "rel_tick_g0");
    step(4'b0100, 4'b0000, 1'b0, "rel_on_tick");
    step(4'b0100, 4'b0000, 1'b0, "no_regrant");
    step(4'b0100, 4'b0000, 1'b0, "no_regrant");
    step(4'b0100, 4'b0000, 1'b0, "no_regrant");
    step(4'b0100, 4'b0100, 1'b0, "next_tick_g2");
    step(4'b0000, 4'b0000, 1'b0, "final_release");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
